// File: rtl/clock_pkg.sv
// Shared constants, state encodings and slice/mode helpers for the mode scheduler and its key detectors.
package clock_pkg;

  localparam int NUM_MODES = 5;
  localparam int SLICE_W   = 24;

  localparam logic [2:0] MODE_1 = 3'd0;
  localparam logic [2:0] MODE_2 = 3'd1;
  localparam logic [2:0] MODE_3 = 3'd2;
  localparam logic [2:0] MODE_4 = 3'd3;
  localparam logic [2:0] MODE_5 = 3'd4;

  typedef enum logic {
    S_RUN,
    S_RING
  } sched_state_t;

  typedef enum logic [1:0] {
    K_IDLE,
    K_DEBOUNCE,
    K_HELD,
    K_LONG_WAIT
  } key_state_t;

  function automatic logic [2:0] next_mode(input logic [2:0] m);
    case (m)
      MODE_1:  return MODE_2;
      MODE_2:  return MODE_3;
      MODE_3:  return MODE_4;
      MODE_4:  return MODE_5;
      default: return MODE_1;
    endcase
  endfunction

  function automatic logic [NUM_MODES-1:0] mode_onehot(input logic [2:0] m);
    case (m)
      MODE_1:  return 5'b00001;
      MODE_2:  return 5'b00010;
      MODE_3:  return 5'b00100;
      MODE_4:  return 5'b01000;
      MODE_5:  return 5'b10000;
      default: return 5'b00001;
    endcase
  endfunction

  function automatic logic [SLICE_W-1:0] pick_slice(input logic [NUM_MODES*SLICE_W-1:0] d,
                                                    input logic [2:0] m);
    case (m)
      MODE_2:  return d[2*SLICE_W-1:1*SLICE_W];
      MODE_3:  return d[3*SLICE_W-1:2*SLICE_W];
      MODE_4:  return d[4*SLICE_W-1:3*SLICE_W];
      MODE_5:  return d[5*SLICE_W-1:4*SLICE_W];
      default: return d[1*SLICE_W-1:0];
    endcase
  endfunction

endpackage

// File: rtl/key_press_detect.sv
// Debounces one key and classifies the press: short_p one cycle after release, long_p when the hold
// reaches LONG_CYCLES; both registered single-cycle pulses, no backpressure.
module key_press_detect
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic short_p,
  output logic long_p
);

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // Saturating increment so a stuck key can never wrap into a false decision.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= K_IDLE;
      cnt     <= '0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
    end else begin
      short_p <= 1'b0;
      long_p  <= 1'b0;
      case (state)
        K_IDLE: begin
          if (key) begin
            state <= K_DEBOUNCE;
            cnt   <= CNT_W'(1);
          end
        end
        K_DEBOUNCE: begin
          if (!key) begin
            state <= K_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= CNT_W'(DEBOUNCE_CYCLES)) state <= K_HELD;
          end
        end
        K_HELD: begin
          if (!key) begin
            short_p <= 1'b1;
            state   <= K_IDLE;
            cnt     <= '0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc >= CNT_W'(LONG_CYCLES)) begin
              long_p <= 1'b1;
              state  <= K_LONG_WAIT;
            end
          end
        end
        K_LONG_WAIT: begin
          if (!key) begin
            state <= K_IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= K_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mode_scheduler.sv
// Routes keys, display and buzzer among five modes; pulses/mode/display are registered (1 cycle), no backpressure.
// MODE_SCHEDULER_BUZZ_BLINK_EN: buzzer blinks with BLINK_CYCLES half-period while ringing instead of steady on.
module mode_scheduler
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int CNT_W           = 26
) (
  input  logic                           clk_50MHz,
  input  logic                           rst,
  input  logic                           key_mode,
  input  logic                           key_act,
  input  logic [NUM_MODES*SLICE_W-1:0]   mode_digits,
  input  logic                           timer_signal,
  input  logic                           alarm_signal,
  output logic [2:0]                     mode_sel,
  output logic [NUM_MODES-1:0]           En,
  output logic                           B_S,
  output logic                           B_L,
  output logic                           stopsignal,
  output logic [SLICE_W-1:0]             disp_digits,
  output logic                           buzzer
);

  if (BLINK_CYCLES < 1 || (longint'(1) << CNT_W) <= longint'(LONG_CYCLES)) begin : g_param_err
    $error("mode_scheduler: BLINK_CYCLES must be >= 1 and 2**CNT_W must exceed LONG_CYCLES");
  end

  logic         mode_short, mode_long, act_short, act_long;
  logic         any_press;
  logic         timer_q, alarm_q;
  logic         timer_rise, alarm_rise;
  sched_state_t state;
  logic [2:0]   ring_src;

  key_press_detect #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_mode (
    .clk    (clk_50MHz),
    .rst    (rst),
    .key    (key_mode),
    .short_p(mode_short),
    .long_p (mode_long)
  );

  key_press_detect #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key_act (
    .clk    (clk_50MHz),
    .rst    (rst),
    .key    (key_act),
    .short_p(act_short),
    .long_p (act_long)
  );

  assign any_press  = mode_short | mode_long | act_short | act_long;
  assign timer_rise = timer_signal & ~timer_q;
  assign alarm_rise = alarm_signal & ~alarm_q;

`ifdef MODE_SCHEDULER_BUZZ_BLINK_EN
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  logic [BW-1:0] blink_cnt;
`endif

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state       <= S_RUN;
      ring_src    <= MODE_1;
      mode_sel    <= MODE_1;
      En          <= mode_onehot(MODE_1);
      B_S         <= 1'b0;
      B_L         <= 1'b0;
      stopsignal  <= 1'b0;
      buzzer      <= 1'b0;
      timer_q     <= 1'b0;
      alarm_q     <= 1'b0;
      disp_digits <= pick_slice(mode_digits, MODE_1);
`ifdef MODE_SCHEDULER_BUZZ_BLINK_EN
      blink_cnt   <= '0;
`endif
    end else begin
      B_S         <= 1'b0;
      B_L         <= 1'b0;
      stopsignal  <= 1'b0;
      // Edge registers track the level in every state so a level held across RING cannot re-trigger.
      timer_q     <= timer_signal;
      alarm_q     <= alarm_signal;
      disp_digits <= pick_slice(mode_digits, (state == S_RING) ? ring_src : mode_sel);
      if (state == S_RUN) begin
        if (timer_rise || alarm_rise) begin
          state    <= S_RING;
          ring_src <= timer_rise ? MODE_5 : MODE_4;
          buzzer   <= 1'b1;
`ifdef MODE_SCHEDULER_BUZZ_BLINK_EN
          blink_cnt <= '0;
`endif
        end else begin
          if (mode_short || mode_long) begin
            mode_sel <= next_mode(mode_sel);
            En       <= mode_onehot(next_mode(mode_sel));
          end
          B_S <= act_short;
          B_L <= act_long;
        end
      end else begin
        // The acknowledging press is consumed here and never reaches the active mode.
        if (any_press) begin
          stopsignal <= 1'b1;
          buzzer     <= 1'b0;
          state      <= S_RUN;
`ifdef MODE_SCHEDULER_BUZZ_BLINK_EN
          blink_cnt  <= '0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
          blink_cnt <= '0;
          buzzer    <= ~buzzer;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
`endif
        end
      end
    end
  end

endmodule

// File: doc/mode_scheduler.md
Name: mode_scheduler

Overview:
- Top-level controller that shares the clock's physical inputs and display among the five mode blocks, mode_1 through mode_5. Mode 5 is the timer.
- Debounces two raw keys and classifies each press as short or long. Only the active mode receives its En and B_S/B_L pulses.
- Selects which mode's six BCD digits drive the display.
- Arbitrates end-of-count events: the timer signal and the alarm signal force the display to the ringing mode and the buzzer on, and a key press acknowledges the event via stopsignal.

Parameters:
- DEBOUNCE_CYCLES, 500000: stable-high cycles before a press is accepted (10 ms at 50 MHz).
- LONG_CYCLES, 50000000: held cycles, counted from the start of debounce, that make a press long (1 s).
- BLINK_CYCLES, 12500000: buzzer half-period, used only with BUZZ_BLINK_EN.
- CNT_W, 26: width of the debounce/hold counter; must satisfy 2^CNT_W > LONG_CYCLES.

Ports:
- clk_50MHz  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_mode  in  1  raw mode key, already synchronised, active-high.
- key_act  in  1  raw action key, already synchronised, active-high.
- mode_digits  in  120  six BCD digits per mode, 24 bits per mode. Mode k occupies [24k+23:24k]; digit order within each slice is sechun_10..min_1, MSB first.
- timer_signal  in  1  end-of-count level from mode 5.
- alarm_signal  in  1  alarm match level from mode 4.
- mode_sel  out  3  active mode, 0..4.
- En  out  5  one-hot enable; En[mode_sel]=1.
- B_S  out  1  one-cycle short-press pulse, action key.
- B_L  out  1  one-cycle long-press pulse, action key.
- stopsignal  out  1  one-cycle event acknowledge.
- disp_digits  out  24  selected six BCD digits.
- buzzer  out  1  buzzer drive.

Behaviour:
Reset values:
- mode_sel=0, En=5'b00001.
- B_S=0, B_L=0, stopsignal=0, buzzer=0.
- Both key detectors in IDLE. Scheduler in RUN.
- disp_digits follows mode slice 0 on the first cycle after reset.

Key detector, one per key. States: IDLE, DEBOUNCE, HELD, LONG_WAIT.
- IDLE: on key=1, go to DEBOUNCE and set cnt=1.
- DEBOUNCE: key=0 returns to IDLE with no event. Otherwise cnt increments; when cnt==DEBOUNCE_CYCLES, go to HELD.
- HELD: cnt keeps incrementing.
  - key=0 before cnt reaches LONG_CYCLES: short pulse for 1 cycle on the cycle after release is sampled; return to IDLE.
  - cnt==LONG_CYCLES: long pulse for 1 cycle; go to LONG_WAIT.
- LONG_WAIT: on key=0, return to IDLE. No event on release.
- cnt saturates; it never wraps.

Scheduler. States: RUN, RING.
RUN:
- mode key short or long press: mode_sel = (mode_sel==4) ? 0 : mode_sel+1. En updates in the same cycle as mode_sel.
- Action-key short press drives B_S; action-key long press drives B_L. Each pulse lasts exactly 1 cycle, the cycle after the detector event.
- timer_signal rising edge (registered compare) → RING with ring_src=4.
- alarm_signal rising edge → RING with ring_src=3.
- Both edges in the same cycle: timer wins (ring_src=4). The alarm edge is dropped.
- An edge in the same cycle as a key event: the event wins, and the key event is discarded.

RING:
- disp_digits shows slice ring_src. mode_sel and En are unchanged, so the background mode keeps its En.
- buzzer=1.
- Any short or long press on either key: stopsignal=1 for 1 cycle; buzzer=0 in that same cycle; return to RUN.
  - The acknowledging press produces no B_S, B_L or mode change.
  - A long press acknowledges at the short/long decision point: the release for a short press, LONG_CYCLES for a long one. The subsequent LONG_WAIT release is silent.
- New rising edges while in RING are ignored.
- If the source level is still high on return to RUN, it does not re-trigger until it falls and rises again.

Other rules:
- disp_digits in RUN is a registered mux of mode_digits at mode_sel: 1-cycle latency.
- B_S, B_L and stopsignal are never high together.
- rst during any state, including mid-press and RING, takes effect on the next edge and yields exactly the reset values.
  - A key still held after reset is treated as a fresh press.

Optional Feature:
- Macro: MODE_SCHEDULER_BUZZ_BLINK_EN.
- Defined: in RING, buzzer toggles every BLINK_CYCLES, starting at 1 on RING entry. The blink counter is cleared on RING exit and on rst.
- Undefined: buzzer is steady 1 in RING, the blink counter is absent, and BLINK_CYCLES is unused.

Decomposition:
- Package clock_pkg holds:
  - mode index constants MODE_1..MODE_5 (0..4) and NUM_MODES=5;
  - the scheduler state encoding;
  - the key-detector state encoding;
  - the digit slice width (24).
- Sub-module key_press_detect, with parameters DEBOUNCE_CYCLES, LONG_CYCLES and CNT_W, outputs short_p and long_p. It is instantiated twice.

Test Plan:
Run with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, BLINK_CYCLES=3.
1. key_act high 3 cycles then low → no B_S/B_L. Held 10 cycles → one B_S pulse after release; B_L stays 0.
2. key_act held 30 cycles → single B_L at cnt 20, no pulse on release. mode_sel unchanged.
3. Five mode-key short presses from reset → mode_sel 1,2,3,4,0; En one-hot each time. disp_digits equals the matching 24-bit slice one cycle after each change.
4. mode_sel=1; timer_signal and alarm_signal rise in the same cycle → RING with disp = slice 4, buzzer=1. Short key_act → one stopsignal, no B_S, back to RUN with disp = slice 1.
5. rst asserted mid-DEBOUNCE and during RING → next cycle has all reset values. No pulse on the subsequent release.
6. With MODE_SCHEDULER_BUZZ_BLINK_EN defined: buzzer reads 1,1,1,0,0,0,1… from RING entry. Without it: steady 1.
